// File: rtl/ifid_hazard_reg_if.sv
// Front-end bundle between fetch, the IF/ID register and the decode stage.
// The master drives fetch/ID-EX/control inputs; the slave (IF/ID register) drives the rest.
interface ifid_hazard_reg_if #(
    parameter int STALL_CNT_W = 16
);
    logic [31:0]            instrIFIn;
    logic [31:0]            PCPlus4In;
    logic                   IDEXMemRead;
    logic [4:0]             IDEXRt;
    logic                   FlushIn;
    logic                   HoldIn;
    logic [31:0]            instrIFIDOut;
    logic [31:0]            PCIFIDOut;
    logic                   ValidOut;
    logic                   PCWrite;
    logic                   BubbleOut;
    logic [STALL_CNT_W-1:0] StallCnt;
    logic [1:0]             dbg_state;

    modport master (
        output instrIFIn, PCPlus4In, IDEXMemRead, IDEXRt, FlushIn, HoldIn,
        input  instrIFIDOut, PCIFIDOut, ValidOut, PCWrite, BubbleOut, StallCnt, dbg_state
    );

    modport slave (
        input  instrIFIn, PCPlus4In, IDEXMemRead, IDEXRt, FlushIn, HoldIn,
        output instrIFIDOut, PCIFIDOut, ValidOut, PCWrite, BubbleOut, StallCnt, dbg_state
    );
endinterface

// File: rtl/ifid_hazard_reg.sv
// IF/ID pipeline register with load-use stall, flush, external hold and a
// saturating stall counter. Priority per cycle: rst > flush > hold > load-use > advance.
module ifid_hazard_reg #(
    parameter int STALL_CNT_W = 16
) (
    input logic              clk,
    input logic              rst,
    ifid_hazard_reg_if.slave bus
);
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LUSTALL = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [31:0]            r_instr;
    logic [31:0]            r_pc;
    logic                   r_valid;
    logic [STALL_CNT_W-1:0] r_stall_cnt;
    logic [4:0]             w_rs;
    logic [4:0]             w_rt;
    logic                   w_lu;
    logic                   w_pc_write;
    logic                   w_bubble;

    // Hazard check uses only the registered slot; a flushed slot never stalls.
    assign w_rs = r_instr[25:21];
    assign w_rt = r_instr[20:16];
    assign w_lu = r_valid && bus.IDEXMemRead && (bus.IDEXRt != 5'd0) &&
                  ((bus.IDEXRt == w_rs) || (bus.IDEXRt == w_rt));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = ST_RUN;
        if (bus.FlushIn) begin
            w_state_nxt = ST_RUN;
        end else if (bus.HoldIn) begin
            w_state_nxt = ST_HOLD;
        end else if (w_lu) begin
            w_state_nxt = ST_LUSTALL;
        end
    end

    always_comb begin
        w_pc_write = 1'b1;
        w_bubble   = 1'b0;
        if (bus.FlushIn) begin
            w_pc_write = 1'b1;
        end else if (bus.HoldIn) begin
            w_pc_write = 1'b0;
        end else if (w_lu) begin
            w_pc_write = 1'b0;
            w_bubble   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr     <= 32'd0;
            r_pc        <= 32'd0;
            r_valid     <= 1'b0;
            r_stall_cnt <= '0;
        end else if (bus.FlushIn) begin
            r_instr <= 32'd0;
            r_pc    <= bus.PCPlus4In;
            r_valid <= 1'b0;
        end else if (bus.HoldIn) begin
            r_instr <= r_instr;
        end else if (w_lu) begin
            if (r_stall_cnt != '1) begin
                r_stall_cnt <= r_stall_cnt + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            r_instr <= bus.instrIFIn;
            r_pc    <= bus.PCPlus4In;
            r_valid <= 1'b1;
        end
    end

    assign bus.instrIFIDOut = r_instr;
    assign bus.PCIFIDOut    = r_pc;
    assign bus.ValidOut     = r_valid;
    assign bus.PCWrite      = w_pc_write;
    assign bus.BubbleOut    = w_bubble;
    assign bus.StallCnt     = r_stall_cnt;
    assign bus.dbg_state    = r_state;
endmodule

// File: tb/tb_ifid_hazard_reg.sv
// Directed bench for ifid_hazard_reg: a 16-bit-counter instance for the main
// scenarios and a 2-bit-counter twin fed the same stimulus for saturation.
module tb_ifid_hazard_reg;
    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    ifid_hazard_reg_if #(.STALL_CNT_W(16)) bus16 ();
    ifid_hazard_reg_if #(.STALL_CNT_W(2))  bus2 ();

    assign bus2.instrIFIn   = bus16.instrIFIn;
    assign bus2.PCPlus4In   = bus16.PCPlus4In;
    assign bus2.IDEXMemRead = bus16.IDEXMemRead;
    assign bus2.IDEXRt      = bus16.IDEXRt;
    assign bus2.FlushIn     = bus16.FlushIn;
    assign bus2.HoldIn      = bus16.HoldIn;

    ifid_hazard_reg #(.STALL_CNT_W(16)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16));
    ifid_hazard_reg #(.STALL_CNT_W(2))  u_dut2  (.clk(clk), .rst(rst), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got running, required finished");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [31:0] instr, input logic [31:0] pc);
        bus16.instrIFIn = instr;
        bus16.PCPlus4In = pc;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus16.IDEXMemRead = 1'b0;
        bus16.IDEXRt = 5'd0;
        bus16.FlushIn = 1'b0;
        bus16.HoldIn = 1'b0;
        feed(32'h8C220004, 32'h4);
        tick();
        tick();
        rst = 1'b0;
        #1;
        n_total++;
        if ({bus16.instrIFIDOut, bus16.PCIFIDOut, bus16.ValidOut} !== 65'd0)
            $display("FAIL reset_regs: got %h/%h/%b, required 0/0/0",
                     bus16.instrIFIDOut, bus16.PCIFIDOut, bus16.ValidOut);
        else n_pass++;
        n_total++;
        if (bus16.StallCnt !== 16'd0 || bus16.dbg_state !== 2'd0)
            $display("FAIL reset_cnt_state: got %0d/%0d, required 0/0", bus16.StallCnt, bus16.dbg_state);
        else n_pass++;
        n_total++;
        if (bus16.PCWrite !== 1'b1 || bus16.BubbleOut !== 1'b0)
            $display("FAIL reset_comb: got pcw=%b bub=%b, required 1/0", bus16.PCWrite, bus16.BubbleOut);
        else n_pass++;
        tick();
        n_total++;
        if (bus16.instrIFIDOut !== 32'h8C220004 || bus16.PCIFIDOut !== 32'h4 || bus16.ValidOut !== 1'b1)
            $display("FAIL first_capture: got %h/%h/%b, required 8c220004/00000004/1",
                     bus16.instrIFIDOut, bus16.PCIFIDOut, bus16.ValidOut);
        else n_pass++;
    endtask

    task automatic test_load_use();
        feed(32'h00421820, 32'h8);
        tick();
        bus16.IDEXMemRead = 1'b1;
        bus16.IDEXRt = 5'd2;
        feed(32'h00643020, 32'hC);
        #1;
        n_total++;
        if (bus16.BubbleOut !== 1'b1 || bus16.PCWrite !== 1'b0)
            $display("FAIL lu_comb: got bub=%b pcw=%b, required 1/0", bus16.BubbleOut, bus16.PCWrite);
        else n_pass++;
        tick();
        n_total++;
        if (bus16.instrIFIDOut !== 32'h00421820 || bus16.PCIFIDOut !== 32'h8 ||
            bus16.StallCnt !== 16'd1 || bus16.dbg_state !== 2'd1)
            $display("FAIL lu_hold: got %h/%h cnt=%0d st=%0d, required 00421820/00000008 cnt=1 st=1",
                     bus16.instrIFIDOut, bus16.PCIFIDOut, bus16.StallCnt, bus16.dbg_state);
        else n_pass++;
        bus16.IDEXMemRead = 1'b0;
        #1;
        n_total++;
        if (bus16.BubbleOut !== 1'b0 || bus16.PCWrite !== 1'b1)
            $display("FAIL lu_release: got bub=%b pcw=%b, required 0/1", bus16.BubbleOut, bus16.PCWrite);
        else n_pass++;
        tick();
        n_total++;
        if (bus16.instrIFIDOut !== 32'h00643020 || bus16.PCIFIDOut !== 32'hC || bus16.dbg_state !== 2'd0)
            $display("FAIL lu_advance: got %h/%h st=%0d, required 00643020/0000000c st=0",
                     bus16.instrIFIDOut, bus16.PCIFIDOut, bus16.dbg_state);
        else n_pass++;
    endtask

    task automatic test_no_hazard();
        feed(32'h00001020, 32'h10);
        tick();
        bus16.IDEXMemRead = 1'b1;
        bus16.IDEXRt = 5'd0;
        #1;
        n_total++;
        if (bus16.BubbleOut !== 1'b0 || bus16.PCWrite !== 1'b1)
            $display("FAIL reg0_no_hazard: got bub=%b pcw=%b, required 0/1", bus16.BubbleOut, bus16.PCWrite);
        else n_pass++;
        bus16.IDEXMemRead = 1'b0;
        feed(32'h00421820, 32'h14);
        tick();
        bus16.IDEXMemRead = 1'b1;
        bus16.IDEXRt = 5'd5;
        #1;
        n_total++;
        if (bus16.BubbleOut !== 1'b0 || bus16.PCWrite !== 1'b1)
            $display("FAIL nomatch_no_hazard: got bub=%b pcw=%b, required 0/1", bus16.BubbleOut, bus16.PCWrite);
        else n_pass++;
        // rt-only match: rs=5, rt=2 in IF/ID against a load to $2
        feed(32'h00A21820, 32'h18);
        tick();
        bus16.IDEXRt = 5'd2;
        #1;
        n_total++;
        if (bus16.BubbleOut !== 1'b1 || bus16.PCWrite !== 1'b0)
            $display("FAIL rt_match_hazard: got bub=%b pcw=%b, required 1/0", bus16.BubbleOut, bus16.PCWrite);
        else n_pass++;
        bus16.IDEXMemRead = 1'b0;
        #1;
    endtask

    task automatic test_flush();
        feed(32'h00421820, 32'h20);
        tick();
        bus16.IDEXMemRead = 1'b1;
        bus16.IDEXRt = 5'd2;
        bus16.FlushIn = 1'b1;
        feed(32'h11111111, 32'h24);
        #1;
        n_total++;
        if (bus16.BubbleOut !== 1'b0 || bus16.PCWrite !== 1'b1)
            $display("FAIL flush_comb: got bub=%b pcw=%b, required 0/1", bus16.BubbleOut, bus16.PCWrite);
        else n_pass++;
        tick();
        n_total++;
        if (bus16.instrIFIDOut !== 32'd0 || bus16.ValidOut !== 1'b0 || bus16.PCIFIDOut !== 32'h24 ||
            bus16.StallCnt !== 16'd1 || bus16.dbg_state !== 2'd0)
            $display("FAIL flush_regs: got %h/%b/%h cnt=%0d st=%0d, required 00000000/0/00000024 cnt=1 st=0",
                     bus16.instrIFIDOut, bus16.ValidOut, bus16.PCIFIDOut, bus16.StallCnt, bus16.dbg_state);
        else n_pass++;
        bus16.FlushIn = 1'b0;
        #1;
        n_total++;
        if (bus16.BubbleOut !== 1'b0)
            $display("FAIL invalid_slot_mask: got bub=%b, required 0", bus16.BubbleOut);
        else n_pass++;
        bus16.IDEXMemRead = 1'b0;
        tick();
    endtask

    task automatic test_hold();
        feed(32'h00421820, 32'h30);
        tick();
        bus16.HoldIn = 1'b1;
        bus16.IDEXMemRead = 1'b1;
        bus16.IDEXRt = 5'd2;
        feed(32'h22222222, 32'h34);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_total++;
            if (bus16.PCWrite !== 1'b0 || bus16.BubbleOut !== 1'b0)
                $display("FAIL hold_comb[%0d]: got pcw=%b bub=%b, required 0/0", i, bus16.PCWrite, bus16.BubbleOut);
            else n_pass++;
            tick();
            n_total++;
            if (bus16.instrIFIDOut !== 32'h00421820 || bus16.PCIFIDOut !== 32'h30 ||
                bus16.ValidOut !== 1'b1 || bus16.dbg_state !== 2'd2)
                $display("FAIL hold_regs[%0d]: got %h/%h/%b st=%0d, required 00421820/00000030/1 st=2",
                         i, bus16.instrIFIDOut, bus16.PCIFIDOut, bus16.ValidOut, bus16.dbg_state);
            else n_pass++;
        end
        bus16.HoldIn = 1'b0;
        bus16.IDEXMemRead = 1'b0;
        #1;
        n_total++;
        if (bus16.PCWrite !== 1'b1)
            $display("FAIL hold_release_comb: got pcw=%b, required 1", bus16.PCWrite);
        else n_pass++;
        tick();
        n_total++;
        if (bus16.instrIFIDOut !== 32'h22222222 || bus16.PCIFIDOut !== 32'h34 || bus16.dbg_state !== 2'd0)
            $display("FAIL hold_release_capture: got %h/%h st=%0d, required 22222222/00000034 st=0",
                     bus16.instrIFIDOut, bus16.PCIFIDOut, bus16.dbg_state);
        else n_pass++;
        bus16.HoldIn = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus16.HoldIn = 1'b0;
        #1;
        n_total++;
        if (bus16.instrIFIDOut !== 32'd0 || bus16.PCIFIDOut !== 32'd0 || bus16.ValidOut !== 1'b0 ||
            bus16.StallCnt !== 16'd0 || bus16.dbg_state !== 2'd0)
            $display("FAIL rst_in_hold: got %h/%h/%b cnt=%0d st=%0d, required 0/0/0 cnt=0 st=0",
                     bus16.instrIFIDOut, bus16.PCIFIDOut, bus16.ValidOut, bus16.StallCnt, bus16.dbg_state);
        else n_pass++;
    endtask

    task automatic test_saturation();
        logic [1:0]  exp2 [5];
        logic [15:0] exp16;
        exp2[0] = 2'd1; exp2[1] = 2'd2; exp2[2] = 2'd3; exp2[3] = 2'd3; exp2[4] = 2'd3;
        exp16 = 16'd0;
        for (int i = 0; i < 5; i++) begin
            bus16.IDEXMemRead = 1'b0;
            feed(32'h00421820, 32'h40 + 32'(i * 4));
            tick();
            bus16.IDEXMemRead = 1'b1;
            bus16.IDEXRt = 5'd2;
            tick();
            exp16 = exp16 + 16'd1;
            n_total++;
            if (bus2.StallCnt !== exp2[i] || bus16.StallCnt !== exp16)
                $display("FAIL sat_cnt[%0d]: got w2=%0d w16=%0d, required w2=%0d w16=%0d",
                         i, bus2.StallCnt, bus16.StallCnt, exp2[i], exp16);
            else n_pass++;
        end
        bus16.IDEXMemRead = 1'b0;
        tick();
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        test_reset();
        test_load_use();
        test_no_hazard();
        test_flush();
        test_hold();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
